// File: rtl/agc_loop_ctrl_pkg.sv
// AGC loop controller shared types and defaults.
// State encoding, Q8.8 constants, abs helper.
package agc_loop_ctrl_pkg;

  localparam int unsigned Q_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACQ   = 2'b01,
    ST_TRACK = 2'b10,
    ST_HOLD  = 2'b11
  } agc_state_e;

  localparam logic [Q_W-1:0] MU_FAST_D       = 16'h0040;
  localparam logic [Q_W-1:0] MU_SLOW_D       = 16'h001A;
  localparam logic [Q_W-1:0] LOCK_THRESH_D   = 16'h0020;
  localparam logic [Q_W-1:0] UNLOCK_THRESH_D = 16'h0080;
  localparam int unsigned    LOCK_COUNT_D    = 16;
  localparam int unsigned    UNLOCK_COUNT_D  = 8;
  localparam int unsigned    ACQ_TIMEOUT_D   = 1024;
  localparam int unsigned    HOLD_TIMEOUT_D  = 4096;

  // Two's-complement magnitude; the most negative code saturates.
  function automatic logic [Q_W-1:0] abs_sat(
    input logic [Q_W-1:0] v
  );
    if (v == 16'h8000) return 16'h7FFF;
    else if (v[Q_W-1]) return -v;
    else return v;
  endfunction

endpackage

// File: rtl/agc_loop_ctrl_if.sv
// AGC loop controller signal bundle.
// master = burst framer/error side, slave = controller.
interface agc_loop_ctrl_if;
  import agc_loop_ctrl_pkg::*;

  logic           i_enable;
  logic           i_burst_start;
  logic           i_burst_end;
  logic [Q_W-1:0] i_error;
  logic [Q_W-1:0] o_mu;
  logic           o_gain_hold;
  logic           o_gain_load;
  logic           o_locked;
  logic           o_acq_fail;
  logic [1:0]     o_state;

  modport master (
    output i_enable, i_burst_start,
    output i_burst_end, i_error,
    input  o_mu, o_gain_hold,
    input  o_gain_load, o_locked,
    input  o_acq_fail, o_state
  );

  modport slave (
    input  i_enable, i_burst_start,
    input  i_burst_end, i_error,
    output o_mu, o_gain_hold,
    output o_gain_load, o_locked,
    output o_acq_fail, o_state
  );

endinterface

// File: rtl/agc_loop_ctrl_run_counter.sv
// Saturating consecutive-condition counter.
// o_hit flags the sample that brings the run to LIMIT.
module agc_loop_ctrl_run_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_cond,
  output logic o_hit
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  logic [W-1:0] r_cnt;

  assign o_hit = i_cond && (r_cnt >= LAST);

  // Count consecutive true samples, saturating at LIMIT.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !i_cond)
      r_cnt <= '0;
    else if (r_cnt != TOP)
      r_cnt <= r_cnt + W'(1);
  end

endmodule

// File: rtl/agc_loop_ctrl.sv
// AGC loop sequencing controller.
// IDLE/ACQUIRE/TRACK/HOLD FSM driving mu/hold/load.
module agc_loop_ctrl
  import agc_loop_ctrl_pkg::*;
#(
  parameter logic [Q_W-1:0] MU_FAST       = MU_FAST_D,
  parameter logic [Q_W-1:0] MU_SLOW       = MU_SLOW_D,
  parameter logic [Q_W-1:0] LOCK_THRESH   = LOCK_THRESH_D,
  parameter logic [Q_W-1:0] UNLOCK_THRESH = UNLOCK_THRESH_D,
  parameter int unsigned    LOCK_COUNT    = LOCK_COUNT_D,
  parameter int unsigned    UNLOCK_COUNT  = UNLOCK_COUNT_D,
  parameter int unsigned    ACQ_TIMEOUT   = ACQ_TIMEOUT_D,
  parameter int unsigned    HOLD_TIMEOUT  = HOLD_TIMEOUT_D
) (
  input  logic            i_clk,
  input  logic            i_rst,
  agc_loop_ctrl_if.slave  bus
);

  agc_state_e     r_state;
  logic [Q_W-1:0] r_mu;
  logic           r_hold;
  logic           r_load;
  logic           r_locked;
  logic           r_fail;

  agc_state_e     w_nxt;
  logic           w_fail;
  logic           w_start;
  logic           w_trans;
  logic [Q_W-1:0] w_abs;
  logic           w_lock_hit;
  logic           w_unlock_hit;
  logic           w_acq_to;
  logic           w_hold_to;

  assign w_abs   = abs_sat(bus.i_error);
  assign w_start = bus.i_burst_start
                 & ~bus.i_burst_end;
  assign w_trans = (w_nxt != r_state);

  agc_loop_ctrl_run_counter #(
    .LIMIT (LOCK_COUNT)
  ) u_lock (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_trans),
    .i_cond ((r_state == ST_ACQ)
             && (w_abs <= LOCK_THRESH)),
    .o_hit  (w_lock_hit)
  );

  agc_loop_ctrl_run_counter #(
    .LIMIT (UNLOCK_COUNT)
  ) u_unlock (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_trans),
    .i_cond ((r_state == ST_TRACK)
             && (w_abs > UNLOCK_THRESH)),
    .o_hit  (w_unlock_hit)
  );

  agc_loop_ctrl_run_counter #(
    .LIMIT (ACQ_TIMEOUT)
  ) u_acq_dwell (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_trans),
    .i_cond (r_state == ST_ACQ),
    .o_hit  (w_acq_to)
  );

  agc_loop_ctrl_run_counter #(
    .LIMIT (HOLD_TIMEOUT)
  ) u_hold_dwell (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_trans),
    .i_cond (r_state == ST_HOLD),
    .o_hit  (w_hold_to)
  );

  // Next state: enable, framing, timeout, counts.
  always_comb begin
    w_nxt  = r_state;
    w_fail = 1'b0;
    if (!bus.i_enable) begin
      w_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) w_nxt = ST_ACQ;
        end
        ST_ACQ: begin
          if (bus.i_burst_end) begin
            w_nxt = ST_IDLE;
          end else if (w_acq_to) begin
            w_nxt  = ST_IDLE;
            w_fail = 1'b1;
          end else if (w_lock_hit) begin
            w_nxt = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (bus.i_burst_end) w_nxt = ST_HOLD;
          else if (w_unlock_hit) w_nxt = ST_ACQ;
        end
        ST_HOLD: begin
          if (w_start) w_nxt = ST_TRACK;
          else if (w_hold_to) w_nxt = ST_IDLE;
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  // State and registered per-state outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_mu     <= '0;
      r_hold   <= 1'b1;
      r_load   <= 1'b0;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_fail  <= w_fail;
      r_load  <= (r_state == ST_IDLE)
              && (w_nxt == ST_ACQ);
      r_hold  <= (w_nxt == ST_IDLE)
              || (w_nxt == ST_HOLD);
      r_locked <= (w_nxt == ST_TRACK)
               || ((w_nxt == ST_HOLD)
                   && r_locked);
      unique case (1'b1)
        (w_nxt == ST_ACQ):   r_mu <= MU_FAST;
        (w_nxt == ST_TRACK): r_mu <= MU_SLOW;
        default:             r_mu <= '0;
      endcase
    end
  end

  assign bus.o_state     = r_state;
  assign bus.o_mu        = r_mu;
  assign bus.o_gain_hold = r_hold;
  assign bus.o_gain_load = r_load;
  assign bus.o_locked    = r_locked;
  assign bus.o_acq_fail  = r_fail;

endmodule
